// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the EX-stage ALU control block.
//   - ALU Func select codes driven to the ALU
//   - ALU_mid I-type class codes (3'b111 selects R-type funct decode)
//   - R-type funct constants, including mul/div and HI/LO moves
//   - multiply/divide sequencer state encoding
package alu_pkg;

   localparam logic [3:0] FUNC_AND  = 4'b0000;
   localparam logic [3:0] FUNC_OR   = 4'b0001;
   localparam logic [3:0] FUNC_XOR  = 4'b0010;
   localparam logic [3:0] FUNC_XNOR = 4'b0011;
   localparam logic [3:0] FUNC_ADD  = 4'b0100;
   localparam logic [3:0] FUNC_SUB  = 4'b1100;
   localparam logic [3:0] FUNC_SLT  = 4'b1101;

   localparam logic [2:0] MID_ADD   = 3'b000;
   localparam logic [2:0] MID_SUB   = 3'b001;
   localparam logic [2:0] MID_AND   = 3'b010;
   localparam logic [2:0] MID_OR    = 3'b011;
   localparam logic [2:0] MID_XOR   = 3'b100;
   localparam logic [2:0] MID_SLT   = 3'b101;
   localparam logic [2:0] MID_ILL   = 3'b110;
   localparam logic [2:0] MID_RTYPE = 3'b111;

   localparam logic [5:0] FUNCT_ADD   = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
   localparam logic [5:0] FUNCT_SUB   = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
   localparam logic [5:0] FUNCT_AND   = 6'b100100;
   localparam logic [5:0] FUNCT_OR    = 6'b100101;
   localparam logic [5:0] FUNCT_XOR   = 6'b100110;
   localparam logic [5:0] FUNCT_XNOR  = 6'b001100;
   localparam logic [5:0] FUNCT_SLT   = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      SEQ_IDLE = 2'b00,
      SEQ_MUL  = 2'b01,
      SEQ_DIV  = 2'b10,
      SEQ_FIX  = 2'b11
   } seq_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer owning the HI/LO registers.
// Only built when ALU_MULDIV_EN is defined.
//   clk, rst_n        clock, synchronous active-low reset
//   start_i           issue a mult/div (only honoured in IDLE)
//   div_i, signed_i   operation select for the issue
//   wr_hi_i, wr_lo_i  mthi/mtlo write of a_i (only honoured in IDLE)
//   a_i, b_i          operands (rs, rt)
//   hi_o, lo_o        architectural HI/LO
//   busy_o            sequencer not idle
//
// state    | meaning
// SEQ_IDLE | waiting; accepts issue and mthi/mtlo
// SEQ_MUL  | shift-add, one multiplier bit per cycle
// SEQ_DIV  | restoring divide, one quotient bit per cycle
// SEQ_FIX  | sign correction and {HI,LO} write
`ifdef ALU_MULDIV_EN
module muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             div_i,
   input  logic             signed_i,
   input  logic             wr_hi_i,
   input  logic             wr_lo_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             busy_o
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   seq_state_e       st_q, st_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opb_q, opb_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             div_q, div_d, neg_q, neg_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
   logic             sa, sb;
   logic [WIDTH:0]   mul_sum, div_sh;
   logic [WIDTH-1:0] div_diff;
   logic             div_ge;

   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      opb_d     = opb_q;
      div_d     = div_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      sa        = signed_i & a_i[WIDTH-1];
      sb        = signed_i & b_i[WIDTH-1];
      mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);
      div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ge    = (div_sh >= {1'b0, opb_q});
      // remainder stays below the divisor, so the low bits are exact
      div_diff  = div_sh[WIDTH-1:0] - opb_q;

      case (st_q)
         SEQ_IDLE: begin
            if (wr_hi_i) hi_d = a_i;
            if (wr_lo_i) lo_d = a_i;
            if (start_i) begin
               st_d      = div_i ? SEQ_DIV : SEQ_MUL;
               cnt_d     = CNT_LAST;
               acc_hi_d  = '0;
               acc_lo_d  = sa ? -a_i : a_i;
               opb_d     = sb ? -b_i : b_i;
               div_d     = div_i;
               neg_d     = sa ^ sb;
               neg_rem_d = sa;
               div0_d    = (b_i == '0);
            end
         end
         SEQ_MUL, SEQ_DIV: begin
            if (st_q == SEQ_MUL) begin
               acc_hi_d = mul_sum[WIDTH:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end else begin
               acc_hi_d = div_ge ? div_diff : div_sh[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
            end
            if (cnt_q == '0) st_d = SEQ_FIX;
            else             cnt_d = cnt_q - 1'b1;
         end
         SEQ_FIX: begin
            st_d = SEQ_IDLE;
            if (div_q) begin
               // divide-by-zero keeps the all-ones quotient unsigned
               lo_d = (neg_q & ~div0_q) ? -acc_lo_q : acc_lo_q;
               hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
            end else begin
               {hi_d, lo_d} = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
            end
         end
         default: st_d = SEQ_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q      <= SEQ_IDLE;
         cnt_q     <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         opb_q     <= '0;
         div_q     <= 1'b0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         st_q      <= st_d;
         cnt_q     <= cnt_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         opb_q     <= opb_d;
         div_q     <= div_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign busy_o = (st_q != SEQ_IDLE);

endmodule
`endif

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered EX-stage ALU decoder with optional mul/div sequencer.
// Optional feature macro: ALU_MULDIV_EN (mul/div sequencer, HI/LO, stall).
//   clk, rst_n              clock, synchronous active-low reset
//   en, flush               pipeline advance, bubble insert
//   control_unit_funct      R-type funct
//   ALU_mid                 I-type class, 3'b111 = R-type
//   src_a, src_b            operands
//   Func, illegal, hilo_rd  registered decode results
//   hilo_out                HI or LO captured by the last mfhi/mflo
//   stall                   combinational hold request for ID/EX
//   busy                    sequencer running
module alu_ctrl_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             flush,
   input  logic [5:0]       control_unit_funct,
   input  logic [2:0]       ALU_mid,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [3:0]       Func,
   output logic             illegal,
   output logic             hilo_rd,
   output logic [WIDTH-1:0] hilo_out,
   output logic             stall,
   output logic             busy
);

`ifdef ALU_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif

   logic [3:0] dec_func, func_q, func_d;
   logic       dec_ill, ill_q, ill_d, hilo_rd_q, hilo_rd_d;
   logic       md_hit, md_start, md_div, md_signed, md_mfhi, md_mflo, md_mthi, md_mtlo;
   logic       ld;

   always_comb begin
      dec_func  = FUNC_AND;
      dec_ill   = 1'b0;
      md_hit    = 1'b0;
      md_start  = 1'b0;
      md_div    = 1'b0;
      md_signed = 1'b0;
      md_mfhi   = 1'b0;
      md_mflo   = 1'b0;
      md_mthi   = 1'b0;
      md_mtlo   = 1'b0;
      case (ALU_mid)
         MID_ADD: dec_func = FUNC_ADD;
         MID_SUB: dec_func = FUNC_SUB;
         MID_AND: dec_func = FUNC_AND;
         MID_OR:  dec_func = FUNC_OR;
         MID_XOR: dec_func = FUNC_XOR;
         MID_SLT: dec_func = FUNC_SLT;
         MID_RTYPE: begin
            case (control_unit_funct)
               FUNCT_ADD, FUNCT_ADDU: dec_func = FUNC_ADD;
               FUNCT_SUB, FUNCT_SUBU: dec_func = FUNC_SUB;
               FUNCT_AND:             dec_func = FUNC_AND;
               FUNCT_OR:              dec_func = FUNC_OR;
               FUNCT_XOR:             dec_func = FUNC_XOR;
               FUNCT_XNOR:            dec_func = FUNC_XNOR;
               FUNCT_SLT, FUNCT_SLTU: dec_func = FUNC_SLT;
               FUNCT_MULT:  begin md_hit = 1'b1; md_start = 1'b1; md_signed = 1'b1; end
               FUNCT_MULTU: begin md_hit = 1'b1; md_start = 1'b1; end
               FUNCT_DIV:   begin md_hit = 1'b1; md_start = 1'b1; md_div = 1'b1; md_signed = 1'b1; end
               FUNCT_DIVU:  begin md_hit = 1'b1; md_start = 1'b1; md_div = 1'b1; end
               FUNCT_MFHI:  begin md_hit = 1'b1; md_mfhi = 1'b1; end
               FUNCT_MFLO:  begin md_hit = 1'b1; md_mflo = 1'b1; end
               FUNCT_MTHI:  begin md_hit = 1'b1; md_mthi = 1'b1; end
               FUNCT_MTLO:  begin md_hit = 1'b1; md_mtlo = 1'b1; end
               default:     dec_ill = 1'b1;
            endcase
            if (md_hit) begin
               dec_func = MD_EN ? FUNC_ADD : FUNC_AND;
               dec_ill  = ~MD_EN;
            end
         end
         default: dec_ill = 1'b1;
      endcase
   end

   assign ld        = en & ~stall;
   assign func_d    = flush ? FUNC_AND : dec_func;
   assign ill_d     = ~flush & dec_ill;
   assign hilo_rd_d = MD_EN & ~flush & (md_mfhi | md_mflo);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         func_q    <= FUNC_AND;
         ill_q     <= 1'b0;
         hilo_rd_q <= 1'b0;
      end else if (ld) begin
         func_q    <= func_d;
         ill_q     <= ill_d;
         hilo_rd_q <= hilo_rd_d;
      end
   end

   assign Func    = func_q;
   assign illegal = ill_q;
   assign hilo_rd = hilo_rd_q;

`ifdef ALU_MULDIV_EN
   logic [WIDTH-1:0] hi_w, lo_w, hilo_out_q;
   logic             issue;

   assign issue = ld & ~flush;
   // a flushed slot decodes as a bubble, so it never needs to wait
   assign stall = busy & ~flush & md_hit;

   muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (issue & md_start),
      .div_i    (md_div),
      .signed_i (md_signed),
      .wr_hi_i  (issue & md_mthi),
      .wr_lo_i  (issue & md_mtlo),
      .a_i      (src_a),
      .b_i      (src_b),
      .hi_o     (hi_w),
      .lo_o     (lo_w),
      .busy_o   (busy)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)                          hilo_out_q <= '0;
      else if (issue & (md_mfhi | md_mflo)) hilo_out_q <= md_mfhi ? hi_w : lo_w;
   end

   assign hilo_out = hilo_out_q;
`else
   logic unused_md;
   assign unused_md = ^{src_a, src_b, md_start, md_div, md_signed, md_mthi, md_mtlo};
   assign busy      = 1'b0;
   assign stall     = 1'b0;
   assign hilo_out  = '0;
`endif

endmodule

// File: tb/tb_alu_ctrl_seq.sv
module tb_alu_ctrl_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n, en, flush;
   logic [5:0]   fn;
   logic [2:0]   mid;
   logic [W-1:0] a, b;
   logic [3:0]   Func;
   logic         illegal, hilo_rd, stall, busy;
   logic [W-1:0] hilo_out;

   int n_pass = 0;
   int n_tot  = 0;
   int cyc;

   typedef struct packed {
      logic [2:0] mid;
      logic [5:0] fn;
      logic [3:0] func;
      logic       ill;
   } dec_t;

   dec_t tbl [0:17] = '{
      '{3'b111, 6'b100000, 4'b0100, 1'b0}, '{3'b111, 6'b100001, 4'b0100, 1'b0},
      '{3'b111, 6'b100010, 4'b1100, 1'b0}, '{3'b111, 6'b100011, 4'b1100, 1'b0},
      '{3'b111, 6'b100100, 4'b0000, 1'b0}, '{3'b111, 6'b100101, 4'b0001, 1'b0},
      '{3'b111, 6'b100110, 4'b0010, 1'b0}, '{3'b111, 6'b001100, 4'b0011, 1'b0},
      '{3'b111, 6'b101010, 4'b1101, 1'b0}, '{3'b111, 6'b101011, 4'b1101, 1'b0},
      '{3'b111, 6'b000111, 4'b0000, 1'b1}, '{3'b000, 6'b000000, 4'b0100, 1'b0},
      '{3'b001, 6'b000000, 4'b1100, 1'b0}, '{3'b010, 6'b000000, 4'b0000, 1'b0},
      '{3'b011, 6'b000000, 4'b0001, 1'b0}, '{3'b100, 6'b000000, 4'b0010, 1'b0},
      '{3'b101, 6'b000000, 4'b1101, 1'b0}, '{3'b110, 6'b000000, 4'b0000, 1'b1}
   };

   alu_ctrl_seq #(.WIDTH(W)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .en                 (en),
      .flush              (flush),
      .control_unit_funct (fn),
      .ALU_mid            (mid),
      .src_a              (a),
      .src_b              (b),
      .Func               (Func),
      .illegal            (illegal),
      .hilo_rd            (hilo_rd),
      .hilo_out           (hilo_out),
      .stall              (stall),
      .busy               (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic [2:0] m, input logic [5:0] f,
                         input logic [W-1:0] va, input logic [W-1:0] vb);
      mid = m;
      fn  = f;
      a   = va;
      b   = vb;
   endtask

   // present an op, then a plain ADD, and count cycles with busy high after the issue edge
   task automatic issue_wait(input logic [5:0] f, input logic [W-1:0] va,
                             input logic [W-1:0] vb, output int n);
      set_in(3'b111, f, va, vb);
      tick();
      set_in(3'b111, 6'b100000, '0, '0);
      n = 0;
      while (busy && n < 200) begin
         n++;
         tick();
      end
      if (n >= 200) chk("busy_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic read_hl(input logic [5:0] f, input string tag, input logic [W-1:0] exp);
      set_in(3'b111, f, '0, '0);
      tick();
      chk(tag, hilo_out, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      en    = 1'($urandom);
      flush = 1'($urandom);
      set_in(3'($urandom), 6'($urandom), $urandom, $urandom);
      tick(); tick();
      chk("rst_func",     {28'd0, Func},    32'd0);
      chk("rst_illegal",  {31'd0, illegal}, 32'd0);
      chk("rst_hilo_rd",  {31'd0, hilo_rd}, 32'd0);
      chk("rst_hilo_out", hilo_out,         32'd0);
      chk("rst_busy",     {31'd0, busy},    32'd0);
      chk("rst_stall",    {31'd0, stall},   32'd0);

      rst_n = 1'b1;
      en    = 1'b1;
      flush = 1'b0;
      for (int i = 0; i < 18; i++) begin
         set_in(tbl[i].mid, tbl[i].fn, 32'h1234, 32'h5678);
         tick();
         chk($sformatf("dec_func_%0d", i), {28'd0, Func},    {28'd0, tbl[i].func});
         chk($sformatf("dec_ill_%0d", i),  {31'd0, illegal}, {31'd0, tbl[i].ill});
      end

      // flush after an illegal decode
      flush = 1'b1;
      set_in(3'b111, 6'b100010, '0, '0);
      tick();
      chk("flush_func", {28'd0, Func},    32'd0);
      chk("flush_ill",  {31'd0, illegal}, 32'd0);
      flush = 1'b0;
      tick();
      chk("post_flush_sub", {28'd0, Func}, 32'hC);

      // en=0 holds the registered decode
      set_in(3'b111, 6'b100101, '0, '0);
      tick();
      en = 1'b0;
      set_in(3'b111, 6'b100110, '0, '0);
      tick(); tick();
      chk("hold_func", {28'd0, Func}, 32'h1);
      en = 1'b1;
      tick();
      chk("resume_func", {28'd0, Func}, 32'h2);

`ifdef ALU_MULDIV_EN
      // mult -3 * 7 with an mfhi right behind it
      set_in(3'b111, 6'b011000, 32'hFFFF_FFFD, 32'd7);
      tick();
      chk("mult_func", {28'd0, Func},    32'h4);
      chk("mult_ill",  {31'd0, illegal}, 32'd0);
      chk("mult_busy", {31'd0, busy},    32'd1);
      set_in(3'b111, 6'b010000, '0, '0);
      #1;
      chk("mfhi_stall", {31'd0, stall}, 32'd1);
      cyc = 1;
      for (int k = 0; k < 100 && busy; k++) begin
         tick();
         if (busy) cyc++;
      end
      chk("mult_busy_cycles", cyc,                32'd33);
      chk("mfhi_not_yet",     {31'd0, hilo_rd},   32'd0);
      chk("stall_released",   {31'd0, stall},     32'd0);
      tick();
      chk("mfhi_hilo_rd", {31'd0, hilo_rd}, 32'd1);
      chk("mult_hi",      hilo_out,         32'hFFFF_FFFF);
      read_hl(6'b010010, "mult_lo", 32'hFFFF_FFEB);

      issue_wait(6'b011010, 32'hFFFF_FFF9, 32'd2, cyc);
      chk("div_cycles", cyc, 32'd33);
      read_hl(6'b010010, "div_lo", 32'hFFFF_FFFD);
      read_hl(6'b010000, "div_hi", 32'hFFFF_FFFF);

      issue_wait(6'b011011, 32'd7, 32'd0, cyc);
      chk("divu0_cycles", cyc, 32'd33);
      read_hl(6'b010010, "divu0_lo", 32'hFFFF_FFFF);
      read_hl(6'b010000, "divu0_hi", 32'h0000_0007);

      // back-to-back multu; the second waits on busy
      set_in(3'b111, 6'b011001, 32'd5, 32'd5);
      tick();
      set_in(3'b111, 6'b011001, 32'd3, 32'd4);
      cyc = 0;
      for (int k = 0; k < 100 && stall; k++) begin
         cyc++;
         tick();
      end
      chk("b2b_stall_cycles", cyc, 32'd33);
      tick();
      chk("b2b_second_busy", {31'd0, busy}, 32'd1);
      set_in(3'b111, 6'b100000, '0, '0);
      for (int k = 0; k < 100 && busy; k++) tick();
      read_hl(6'b010010, "b2b_lo", 32'h0000_000C);
      read_hl(6'b010000, "b2b_hi", 32'h0000_0000);

      // mthi / mtlo, including mtlo stalled behind a running multu
      set_in(3'b111, 6'b010001, 32'h1234_5678, '0);
      tick();
      set_in(3'b111, 6'b011001, 32'd2, 32'd2);
      tick();
      set_in(3'b111, 6'b010011, 32'h9ABC_DEF0, '0);
      #1;
      chk("mtlo_stall", {31'd0, stall}, 32'd1);
      for (int k = 0; k < 100 && stall; k++) tick();
      tick();
      read_hl(6'b010010, "mtlo_lo", 32'h9ABC_DEF0);
      read_hl(6'b010000, "mthi_after_mul", 32'h0000_0000);
      set_in(3'b111, 6'b010001, 32'h1234_5678, '0);
      tick();
      read_hl(6'b010000, "mthi_hi", 32'h1234_5678);

      // reset mid-mult discards the result
      set_in(3'b111, 6'b011000, 32'd5, 32'd5);
      tick();
      set_in(3'b111, 6'b100000, '0, '0);
      repeat (4) tick();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_func", {28'd0, Func}, 32'd0);
      repeat (40) tick();
      read_hl(6'b010000, "rstmid_hi", 32'd0);
      read_hl(6'b010010, "rstmid_lo", 32'd0);
`else
      set_in(3'b111, 6'b011000, 32'd5, 32'd5);
      #1;
      chk("nomd_stall_pre", {31'd0, stall}, 32'd0);
      tick();
      chk("nomd_mult_func", {28'd0, Func},    32'd0);
      chk("nomd_mult_ill",  {31'd0, illegal}, 32'd1);
      chk("nomd_busy",      {31'd0, busy},    32'd0);
      set_in(3'b111, 6'b010000, '0, '0);
      tick();
      chk("nomd_mfhi_ill",     {31'd0, illegal}, 32'd1);
      chk("nomd_mfhi_hilo_rd", {31'd0, hilo_rd}, 32'd0);
      chk("nomd_hilo_out",     hilo_out,         32'd0);
      chk("nomd_stall",        {31'd0, stall},   32'd0);
      set_in(3'b111, 6'b100000, '0, '0);
      tick();
      chk("nomd_add_after", {28'd0, Func}, 32'h4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
